// File: rtl/vsynth_pkg.sv
// Purpose: shared types and widths for the voice allocator and its slot registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vsynth_pkg;

    localparam int NOTE_W    = 7;
    localparam int VEL_W     = 7;
    localparam int AGE_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Event captured at the handshake; the scan and commit only ever look at this copy.
    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  vel;
    } ev_t;

endpackage

// File: rtl/voice_alloc_if.sv
// Purpose: event handshake plus per-slot note/velocity/active buses between parser, allocator and nco bank.
// Latency: n/a (wires only).
// Backpressure: ev_valid/ev_ready; the allocator side owns ev_ready.
// Ports: ev_valid/ev_ready/ev_on/ev_note/ev_vel event channel, all_off panic,
//        note_num_bus/note_vel_bus (slot i at [7i+6:7i]), voice_active, stolen pulse.
interface voice_alloc_if
    import vsynth_pkg::*;
#(
    parameter int VOICES = 4
) ();

    logic                     ev_valid;
    logic                     ev_ready;
    logic                     ev_on;
    logic [NOTE_W-1:0]        ev_note;
    logic [VEL_W-1:0]         ev_vel;
    logic                     all_off;
    logic [NOTE_W*VOICES-1:0] note_num_bus;
    logic [VEL_W*VOICES-1:0]  note_vel_bus;
    logic [VOICES-1:0]        voice_active;
    logic                     stolen;

    // Event source / consumer of the slot buses.
    modport master (
        output ev_valid, ev_on, ev_note, ev_vel, all_off,
        input  ev_ready, note_num_bus, note_vel_bus, voice_active, stolen
    );

    // Allocator.
    modport slave (
        input  ev_valid, ev_on, ev_note, ev_vel, all_off,
        output ev_ready, note_num_bus, note_vel_bus, voice_active, stolen
    );

endinterface

// File: rtl/voice_slot.sv
// Purpose: one voice slot: note/velocity/active registers and a saturating age counter.
// Latency: controls take effect on the next clk edge.
// Backpressure: none; controls are single-cycle strobes from the allocator.
// Ports: clk, rst_n; kill/load/retrig/inc strobes; note_in/vel_in; note/vel/active/age state.
module voice_slot
    import vsynth_pkg::*;
#(
    parameter int AGE_W = AGE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kill,     // silence: active=0, vel=0, age=0, note kept
    input  logic              load,     // new note: note, vel, active=1, age=0
    input  logic              retrig,   // same note again: vel, age=0
    input  logic              inc,      // another slot was the target; grow older
    input  logic [NOTE_W-1:0] note_in,
    input  logic [VEL_W-1:0]  vel_in,
    output logic [NOTE_W-1:0] note,
    output logic [VEL_W-1:0]  vel,
    output logic              active,
    output logic [AGE_W-1:0]  age
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note   <= '0;
            vel    <= '0;
            active <= 1'b0;
            age    <= '0;
        end else if (kill) begin
            // Note is held so the nco keeps its phase continuous across re-use.
            vel    <= '0;
            active <= 1'b0;
            age    <= '0;
        end else if (load) begin
            note   <= note_in;
            vel    <= vel_in;
            active <= 1'b1;
            age    <= '0;
        end else if (retrig) begin
            vel    <= vel_in;
            age    <= '0;
        end else if (inc && (age != {AGE_W{1'b1}})) begin
            age    <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Purpose: polyphonic voice allocator; maps note-on/off events onto VOICES nco slots with oldest-voice stealing.
// Latency: outputs update on the edge ending cycle VOICES+1 after the handshake; one event per VOICES+2 cycles.
// Backpressure: ev_ready low from the handshake until the commit completes, and whenever all_off is high.
// Ports: clk, rst_n (async active-low); bus = voice_alloc_if.slave (event channel, all_off, slot buses, stolen).
module voice_alloc
    import vsynth_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int VW     = 2,
    parameter int AGE_W  = AGE_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    voice_alloc_if.slave  bus
);

    state_t            state;
    logic [VW-1:0]     scan_idx;
    ev_t               ev_q;
    logic              ready_q;
    logic              stolen_q;

    // Scan results, accumulated one slot per cycle.
    logic              match_found;
    logic [VW-1:0]     match_idx;
    logic              free_found;
    logic [VW-1:0]     free_idx;
    logic              old_found;
    logic [VW-1:0]     old_idx;
    logic [AGE_W-1:0]  old_age;

    // Slot state and control strobes.
    logic [NOTE_W-1:0] slot_note [VOICES];
    logic [VEL_W-1:0]  slot_vel  [VOICES];
    logic [AGE_W-1:0]  slot_age  [VOICES];
    logic [VOICES-1:0] slot_active;
    logic [VOICES-1:0] slot_kill;
    logic [VOICES-1:0] slot_load;
    logic [VOICES-1:0] slot_retrig;
    logic [VOICES-1:0] slot_inc;

    logic              ev_rdy;
    logic              note_on;
    logic              steal;
    logic              cur_hit;
    logic              cur_free;
    logic              cur_older;

    assign ev_rdy  = ready_q & ~bus.all_off;
    // Velocity 0 on a note-on is a note-off by MIDI convention.
    assign note_on = ev_q.on && (ev_q.vel != '0);

    // Comparators for the slot currently under scan.
    assign cur_hit   = slot_active[scan_idx] && (slot_note[scan_idx] == ev_q.note);
    assign cur_free  = !slot_active[scan_idx];
    // Strictly greater keeps the lowest index on equal ages.
    assign cur_older = slot_active[scan_idx] && (!old_found || (slot_age[scan_idx] > old_age));

    // Commit decode: pick the target slot and drive the per-slot strobes.
    always_comb begin
        logic [VW-1:0] tgt;
        logic          has_tgt;
        logic          use_retrig;
        slot_kill   = '0;
        slot_load   = '0;
        slot_retrig = '0;
        slot_inc    = '0;
        steal       = 1'b0;
        tgt         = '0;
        has_tgt     = 1'b0;
        use_retrig  = 1'b0;
        if (bus.all_off) begin
            slot_kill = '1;
        end else if (state == ST_COMMIT) begin
            if (note_on) begin
                if (match_found) begin
                    tgt        = match_idx;
                    has_tgt    = 1'b1;
                    use_retrig = 1'b1;
                end else if (free_found) begin
                    tgt     = free_idx;
                    has_tgt = 1'b1;
                end else if (old_found) begin
                    tgt     = old_idx;
                    has_tgt = 1'b1;
                    steal   = 1'b1;
                end
                for (int i = 0; i < VOICES; i++) begin
                    if (has_tgt && (VW'(i) == tgt)) begin
                        slot_retrig[i] = use_retrig;
                        slot_load[i]   = !use_retrig;
                    end else if (slot_active[i]) begin
                        slot_inc[i] = 1'b1;
                    end
                end
            end else if (match_found) begin
                // Note-off only touches the matching slot; other ages are left alone.
                for (int i = 0; i < VOICES; i++) begin
                    if (VW'(i) == match_idx) begin
                        slot_kill[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            scan_idx    <= '0;
            ev_q        <= '0;
            ready_q     <= 1'b0;
            stolen_q    <= 1'b0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_found   <= 1'b0;
            old_idx     <= '0;
            old_age     <= '0;
        end else begin
            stolen_q <= 1'b0;
            if (bus.all_off) begin
                // Panic wins over any handshake or commit in the same cycle.
                state    <= ST_IDLE;
                scan_idx <= '0;
                ready_q  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ready_q <= 1'b1;
                        if (bus.ev_valid && ev_rdy) begin
                            ev_q        <= {bus.ev_on, bus.ev_note, bus.ev_vel};
                            match_found <= 1'b0;
                            match_idx   <= '0;
                            free_found  <= 1'b0;
                            free_idx    <= '0;
                            old_found   <= 1'b0;
                            old_idx     <= '0;
                            old_age     <= '0;
                            scan_idx    <= '0;
                            ready_q     <= 1'b0;
                            state       <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (!match_found && cur_hit) begin
                            match_found <= 1'b1;
                            match_idx   <= scan_idx;
                        end
                        if (!free_found && cur_free) begin
                            free_found <= 1'b1;
                            free_idx   <= scan_idx;
                        end
                        if (cur_older) begin
                            old_found <= 1'b1;
                            old_idx   <= scan_idx;
                            old_age   <= slot_age[scan_idx];
                        end
                        if (scan_idx == VW'(VOICES - 1)) begin
                            state <= ST_COMMIT;
                        end else begin
                            scan_idx <= scan_idx + VW'(1);
                        end
                    end
                    ST_COMMIT: begin
                        stolen_q <= steal;
                        ready_q  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < VOICES; i++) begin : g_slot
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .kill    (slot_kill[i]),
            .load    (slot_load[i]),
            .retrig  (slot_retrig[i]),
            .inc     (slot_inc[i]),
            .note_in (ev_q.note),
            .vel_in  (ev_q.vel),
            .note    (slot_note[i]),
            .vel     (slot_vel[i]),
            .active  (slot_active[i]),
            .age     (slot_age[i])
        );
        assign bus.note_num_bus[i*NOTE_W +: NOTE_W] = slot_note[i];
        assign bus.note_vel_bus[i*VEL_W +: VEL_W]   = slot_vel[i];
    end

    assign bus.voice_active = slot_active;
    assign bus.ev_ready     = ev_rdy;
    assign bus.stolen       = stolen_q;

endmodule
